// File: rtl/hsv_pkg.sv
// Shared definitions for the HSV frame classifier: hue band bounds, class codes, FSM encoding.
package hsv_pkg;

  localparam int NUM_BANDS = 3;

  localparam int H_N_LO = 30;
  localparam int H_N_HI = 45;
  localparam int H_P_LO = 60;
  localparam int H_P_HI = 80;
  localparam int H_K_LO = 100;
  localparam int H_K_HI = 120;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_N    = 2'd1;
  localparam logic [1:0] CLS_P    = 2'd2;
  localparam logic [1:0] CLS_K    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACCUM,
    ST_DECIDE,
    ST_DONE
  } state_t;

  // Band index order is N, P, K; this order is also the tie priority.
  function automatic int band_lo(input int b);
    case (b)
      0:       return H_N_LO;
      1:       return H_P_LO;
      default: return H_K_LO;
    endcase
  endfunction

  function automatic int band_hi(input int b);
    case (b)
      0:       return H_N_HI;
      1:       return H_P_HI;
      default: return H_K_HI;
    endcase
  endfunction

endpackage

// File: rtl/hsv_band_counter.sv
// One hue band: strict (LO, HI) range compare feeding a saturating pixel counter.
module hsv_band_counter #(
  parameter int CNT_W = 20,
  parameter int LO    = 30,
  parameter int HI    = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [8:0]       hue,
  output logic [CNT_W-1:0] cnt
);

  logic hit;
  logic sat;

  assign hit = (hue > 9'(LO)) && (hue < 9'(HI));
  assign sat = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && hit && !sat) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hsv_frame_classifier.sv
// Frame-level hue band classifier: syncs to vsync, optionally skips frames, counts
// one full frame of N/P/K band pixels and reports the dominant class with a done pulse.
module hsv_frame_classifier
  import hsv_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int MIN_PIX    = 1000,
  parameter int FRAME_SKIP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hsv_vsync,
  input  logic             hsv_de,
  input  logic [8:0]       hsv_h,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] cnt_p,
  output logic [CNT_W-1:0] cnt_k,
  output logic [1:0]       class_id
);

  localparam logic [31:0] MIN_W = 32'(MIN_PIX);

  state_t     state, nxt;
  logic       vs_d;
  logic       fs;
  logic [3:0] skip_cnt;
  logic       cnt_clr;
  logic       cnt_en;
  logic       abort_act;

  logic [NUM_BANDS-1:0][CNT_W-1:0] cnt_all;
  logic [CNT_W-1:0]                win_max;
  logic [1:0]                      win_cls;

  assign fs        = hsv_vsync & ~vs_d;
  assign abort_act = abort && (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_d <= 1'b0;
    else        vs_d <= hsv_vsync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort_act) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start && !abort) nxt = ST_SYNC;
        ST_SYNC: begin
          if (fs && skip_cnt == 4'd0) begin
            nxt     = ST_ACCUM;
            cnt_clr = 1'b1;
          end
        end
        // The fs cycle carries vsync=1, so its pixel is never counted.
        ST_ACCUM: begin
          if (fs) nxt = ST_DECIDE;
          else    cnt_en = hsv_de && !hsv_vsync;
        end
        ST_DECIDE: nxt = ST_DONE;
        ST_DONE:   nxt = ST_IDLE;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      skip_cnt <= 4'd0;
    else if (state == ST_IDLE && start && !abort)
      skip_cnt <= 4'(FRAME_SKIP);
    else if (state == ST_SYNC && fs && !abort && skip_cnt != 4'd0)
      skip_cnt <= skip_cnt - 4'd1;
  end

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    hsv_band_counter #(
      .CNT_W (CNT_W),
      .LO    (band_lo(b)),
      .HI    (band_hi(b))
    ) u_band (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .hue   (hsv_h),
      .cnt   (cnt_all[b])
    );
  end

  assign cnt_n = cnt_all[0];
  assign cnt_p = cnt_all[1];
  assign cnt_k = cnt_all[2];

  // Ties resolve N > P > K through the >= ordering.
  always_comb begin
    win_max = cnt_all[0];
    win_cls = CLS_N;
    if (cnt_all[0] >= cnt_all[1] && cnt_all[0] >= cnt_all[2]) begin
      win_max = cnt_all[0];
      win_cls = CLS_N;
    end else if (cnt_all[1] >= cnt_all[2]) begin
      win_max = cnt_all[1];
      win_cls = CLS_P;
    end else begin
      win_max = cnt_all[2];
      win_cls = CLS_K;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      class_id <= CLS_NONE;
    else if (state == ST_DECIDE && !abort)
      class_id <= (32'(win_max) < MIN_W) ? CLS_NONE : win_cls;
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE) && !abort;

endmodule

// File: doc/hsv_frame_classifier.md
Name: hsv_frame_classifier

Overview:
- Frame-level controller that sits downstream of the RGB-to-HSV pixel pipeline and consumes its hue output, vsync and data-enable.
- On a start command it synchronises to a frame boundary and optionally skips settling frames.
- It then counts, over exactly one full frame, the active pixels whose hue falls in each of the three nutrient bands (N, P, K).
- It reports the per-band counts and a dominant-class decision with a one-cycle done pulse.

Parameters:
- CNT_W, 20, width of each band counter; counters saturate at 2^CNT_W-1.
- MIN_PIX, 1000, minimum winning count required to declare a class; below it class_id=0.
- FRAME_SKIP, 1, number of whole frames discarded after sync before accumulation (0..15).

Ports:
- clk  in  1  pixel clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle request; ignored while busy=1.
- abort  in  1  single-cycle cancel; returns to IDLE, no done pulse.
- hsv_vsync  in  1  frame sync from HSV pipeline, active-high.
- hsv_de  in  1  pixel valid from HSV pipeline.
- hsv_h  in  9  hue, 0..360.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are valid.
- cnt_n  out  CNT_W  pixels with 30 < hue < 45.
- cnt_p  out  CNT_W  pixels with 60 < hue < 80.
- cnt_k  out  CNT_W  pixels with 100 < hue < 120.
- class_id  out  2  0=none, 1=N, 2=P, 3=K.

Behaviour:
- Reset: all outputs 0, state IDLE, vs_d=0, skip_cnt=0.
- Frame edge detection:
  - vs_d is hsv_vsync registered.
  - fs (frame start) = hsv_vsync & ~vs_d, evaluated combinationally each cycle.
- FSM states and transitions:
  - IDLE: on start go to SYNC, load skip_cnt=FRAME_SKIP.
  - SYNC: on fs, if skip_cnt==0 go to ACCUM, clearing all three counters in the same cycle; otherwise decrement skip_cnt and stay.
  - ACCUM: each cycle with hsv_de=1 and hsv_vsync=0, increment the matching band counter by 1. Band bounds are strict, as listed under Ports; hues outside every band are ignored. On fs go to DECIDE; the pixel in the fs cycle is not counted.
  - DECIDE (1 cycle): compute max = largest of the counts. Tie priority is N > P > K. If max < MIN_PIX, class_id=0; otherwise the winning code. class_id registers at the end of this cycle.
  - DONE (1 cycle): done=1, then go to IDLE.
- Latency: fs in cycle T gives DECIDE at T+1 and done=1 in cycle T+2. class_id is valid from T+2.
- Output persistence:
  - cnt_* are live during ACCUM and frozen from DECIDE onward.
  - cnt_* and class_id hold until counters are cleared at the next ACCUM entry.
- Saturation: a counter at all-ones stays there; the other counters are unaffected.
- abort:
  - Takes priority over every transition in any state except IDLE.
  - Next state is IDLE; counters and class_id keep their current values; done stays 0.
- start and abort in the same cycle while in IDLE: abort wins, stay IDLE.
- start while busy: ignored, no queuing.
- vsync high already at start: no fs until vsync goes low then high again, so a partial frame is never counted.
- Asynchronous reset mid-frame: immediate return to reset values; the next start behaves as from power-up.

Decomposition:
- Shared package hsv_pkg:
  - Band bounds: H_N_LO=30, H_N_HI=45, H_P_LO=60, H_P_HI=80, H_K_LO=100, H_K_HI=120.
  - Class codes: CLS_NONE=0, CLS_N=1, CLS_P=2, CLS_K=3.
  - FSM state encoding.
- Sub-module hsv_band_counter: one saturating CNT_W counter with clear/enable and a strict range compare. It is instantiated three times.

Test Plan:
- Reset then idle, 3 frames, no start -> busy=0, done never asserted, outputs 0.
- start, FRAME_SKIP=1; frame 1 all hue 40 is skipped; frame 2 has 2000 pixels hue 40, 500 hue 70, 300 hue 200 -> cnt_n=2000, cnt_p=500, cnt_k=0, class_id=1, done exactly 2 cycles after frame-3 fs.
- Boundary hues 30, 45, 60, 80, 100, 120, 31, 44 (one pixel each), MIN_PIX=1 -> cnt_n=2, cnt_p=0, cnt_k=0.
- Tie: 1500 pixels hue 70 and 1500 hue 110 -> class_id=2. Separately 999 pixels hue 110 only, MIN_PIX=1000 -> class_id=0, cnt_k=999.
- CNT_W=4, 20 pixels hue 40 -> cnt_n=15, class_id per MIN_PIX=1 is 1.
- abort mid-ACCUM -> busy=0 next cycle, no done. start pulse while busy -> ignored. rst_n low mid-frame -> all outputs 0 immediately.
